// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding
// and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Encoding 2'd3 is unused and falls back to IDLE in the controller.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_fa_slice.sv
// Single 1-bit full-adder slice, purely combinational; the controller reuses
// it once per bit position.
module serial_fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ cin;
    assign c   = (a & b) | (cin & w_p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice walked LSB-first over
// WIDTH cycles, with valid/ready handshakes on the operand and result sides.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_sum_sh;
    logic             r_carry;
    logic             r_msb_cin;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_sum_next;

    serial_fa_slice u_slice (
        .a   (r_a_sh[0]),
        .b   (r_b_sh[0]),
        .cin (r_carry),
        .s   (w_s),
        .c   (w_c)
    );

    // The LSB of the sum shifter is never needed after the last shift, so only
    // the upper WIDTH-1 bits are stored and the new bit is prepended here.
    assign w_sum_next = {w_s, r_sum_sh};

    // NOTE: every state element is updated with non-blocking assignments so all
    // flops sample pre-edge values; the shift registers are reset too, so an
    // aborted operation can never leak bits into the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum_sh  <= '0;
            r_carry   <= 1'b0;
            r_msb_cin <= 1'b0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_sh <= w_sum_next[WIDTH-1:1];
                    r_carry  <= w_c;
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (r_cnt == CNT_PEN) begin
                        r_msb_cin <= w_c;
                    end
                    if (r_cnt == CNT_LAST) begin
                        sum       <= w_sum_next;
                        cout      <= w_c;
                        ovf       <= r_msb_cin ^ w_c;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
